des_sbox_compress: RTL and testbench

- Inverse-direction companion to the DES expansion stage: contracts the 48-bit post-key-mix word back to 32 bits through the eight DES S-boxes.
- Sits in the round datapath between the round-key XOR and the P-permutation.
- Iterative: evaluates LANES S-boxes per clock, sharing lookup hardware, behind valid/ready handshakes on both sides.

---
 rtl/des_pkg.sv | 37 +++
 rtl/des_sbox_compress_if.sv | 35 +++
 rtl/des_sbox_lookup.sv | 21 ++
 rtl/des_sbox_compress.sv | 118 +++++++++++
 tb/tb_des_sbox_compress.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/des_pkg.sv
// des_pkg: shared definitions for the DES S-box compression stage.
//   SBOX       - the eight DES S-box tables, SBOX[k][row*16+col], k = 1..8
//   stateT     - controller state encoding (IDLE, RUN, DONE)
//   lanesLegal - true for the supported lane counts (1, 2, 4, 8)
//   DATA_IN_W / DATA_OUT_W / NUM_BOXES - datapath widths
package des_pkg;

    localparam int unsigned DATA_IN_W  = 48;
    localparam int unsigned DATA_OUT_W = 32;
    localparam int unsigned NUM_BOXES  = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } stateT;

    // Element 0 of a table is the leftmost nibble of its literal, so each
    // literal reads row 0..3, col 0..15 exactly as the DES tables are printed.
    typedef logic [0:63][3:0] sboxTableT;

    localparam sboxTableT SBOX [1:8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
    };

    function automatic bit lanesLegal(input int unsigned lanes);
        return lanes inside {1, 2, 4, 8};
    endfunction

endpackage

// File: rtl/des_sbox_compress_if.sv
// des_sbox_compress_if: input and output valid/ready handshakes of the
// S-box compression stage.
//   InValid/InReady/DataIn    - 48-bit key-mixed word into the stage
//   OutValid/OutReady/DataOut - 32-bit substituted word out of the stage
//   master - producer/consumer side (drives InValid, DataIn, OutReady)
//   slave  - the compression stage itself
interface des_sbox_compress_if;
    import des_pkg::*;

    logic                  InValid;
    logic                  InReady;
    logic [DATA_IN_W-1:0]  DataIn;
    logic                  OutValid;
    logic                  OutReady;
    logic [DATA_OUT_W-1:0] DataOut;

    modport master (
        output InValid,
        output DataIn,
        output OutReady,
        input  InReady,
        input  OutValid,
        input  DataOut
    );

    modport slave (
        input  InValid,
        input  DataIn,
        input  OutReady,
        output InReady,
        output OutValid,
        output DataOut
    );

endinterface

// File: rtl/des_sbox_lookup.sv
// des_sbox_lookup: one combinational DES S-box evaluation.
//   box   - S-box number minus one (0 selects S1, 7 selects S8)
//   chunk - six input bits, chunk[0] = b1 ... chunk[5] = b6
//   value - 4-bit table entry, value[3] is the MSB of the DES result
module des_sbox_lookup
    import des_pkg::*;
(
    input  logic [2:0] box,
    input  logic [5:0] chunk,
    output logic [3:0] value
);

    logic [3:0] tableSel;
    logic [5:0] entry;

    assign tableSel = {1'b0, box} + 4'd1;
    // row = {b1,b6}, col = {b2,b3,b4,b5}; index = row*16 + col
    assign entry    = {chunk[0], chunk[5], chunk[1], chunk[2], chunk[3], chunk[4]};
    assign value    = SBOX[tableSel][entry];

endmodule

// File: rtl/des_sbox_compress.sv
// des_sbox_compress: contracts the 48-bit key-mixed word to 32 bits through
// the eight DES S-boxes, LANES boxes per clock.
//   Clk  - rising-edge clock
//   Rst  - asynchronous active-high reset
//   bus  - slave side of the in/out valid/ready handshakes
//   Busy - high while a word is being computed or presented
// A word is accepted in IDLE, computed over ITER = 8/LANES cycles in RUN and
// held in DONE until the consumer takes it.
module des_sbox_compress
    import des_pkg::*;
#(
    parameter int unsigned LANES = 1
) (
    input  logic               Clk,
    input  logic               Rst,
    des_sbox_compress_if.slave bus,
    output logic               Busy
);

    localparam int unsigned ITER       = NUM_BOXES / LANES;
    localparam int unsigned LANE_SHIFT = $clog2(LANES);
    localparam logic [2:0]  LAST_CNT   = 3'(ITER - 1);

    if (!lanesLegal(LANES)) begin : gBadLanes
        $error("des_sbox_compress: LANES must be 1, 2, 4 or 8");
    end

    stateT                  state;
    stateT                  nextState;
    logic                   accept;
    logic [DATA_IN_W-1:0]   holdReg;
    logic [7:0][3:0]        result;
    logic [2:0]             cnt;
    logic [2:0]             laneBase;
    logic [5:0]             chunks [8];
    logic [LANES-1:0][2:0]  laneBox;
    logic [LANES-1:0][3:0]  laneVal;

    for (genvar i = 0; i < 8; i++) begin : gChunk
        assign chunks[i] = holdReg[6*i +: 6];
    end

    // Step cnt covers boxes cnt*LANES .. cnt*LANES+LANES-1 (zero-based).
    assign laneBase = cnt << LANE_SHIFT;

    for (genvar l = 0; l < LANES; l++) begin : gLane
        assign laneBox[l] = laneBase + 3'(l);

        des_sbox_lookup uLookup (
            .box   (laneBox[l]),
            .chunk (chunks[laneBox[l]]),
            .value (laneVal[l])
        );
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState    = state;
        accept       = 1'b0;
        bus.InReady  = 1'b0;
        bus.OutValid = 1'b0;
        Busy         = 1'b0;
        case (state)
            IDLE: begin
                // Ready is withheld while reset is applied.
                bus.InReady = !Rst;
                accept      = bus.InValid && !Rst;
                if (accept) begin
                    nextState = RUN;
                end
            end
            RUN: begin
                Busy = 1'b1;
                if (cnt == LAST_CNT) begin
                    nextState = DONE;
                end
            end
            DONE: begin
                Busy         = 1'b1;
                bus.OutValid = 1'b1;
                if (bus.OutReady) begin
                    nextState = IDLE;
                end
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            holdReg <= '0;
            result  <= '0;
            cnt     <= '0;
        end else if (accept) begin
            holdReg <= bus.DataIn;
            result  <= '0;
            cnt     <= '0;
        end else if (state == RUN) begin
            // The DES MSB of each result lands on the lowest bit of its nibble.
            for (int unsigned l = 0; l < LANES; l++) begin
                result[laneBox[l]] <= {laneVal[l][0], laneVal[l][1], laneVal[l][2], laneVal[l][3]};
            end
            cnt <= (cnt == LAST_CNT) ? '0 : cnt + 3'd1;
        end
    end

    assign bus.DataOut = result;

endmodule

// File: tb/tb_des_sbox_compress.sv
// tb_des_sbox_compress: self-checking bench. Four instances (LANES = 1, 2, 4,
// 8) share one stimulus; results are compared against hand-computed DES
// values and an independent S-box table model.
module tb_des_sbox_compress;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        inValid = 1'b0;
    logic        outReady = 1'b0;
    logic [47:0] dataIn = '0;

    logic        ovV   [4];
    logic        irV   [4];
    logic        busyV [4];
    logic [31:0] dout  [4];

    int passCnt  = 0;
    int totalCnt = 0;

    int          lat [4];
    logic [31:0] got [4];

    always #5 Clk = ~Clk;

    for (genvar g = 0; g < 4; g++) begin : gDut
        des_sbox_compress_if bus ();

        assign bus.InValid  = inValid;
        assign bus.DataIn   = dataIn;
        assign bus.OutReady = outReady;
        assign ovV[g]       = bus.OutValid;
        assign irV[g]       = bus.InReady;
        assign dout[g]      = bus.DataOut;

        des_sbox_compress #(.LANES(1 << g)) dut (
            .Clk  (Clk),
            .Rst  (Rst),
            .bus  (bus),
            .Busy (busyV[g])
        );
    end

    // Standard DES S-boxes, [box][row*16+col].
    int tbSbox [8][64] = '{
        '{14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
           0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
           4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
          15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13},
        '{15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
           3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
           0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
          13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9},
        '{10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
          13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
          13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
           1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12},
        '{ 7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
          13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
          10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
           3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14},
        '{ 2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
          14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
           4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
          11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3},
        '{12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
          10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
           9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
           4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13},
        '{ 4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
          13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
           1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
           6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12},
        '{13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
           1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
           7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
           2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11}
    };

    typedef struct {
        logic [47:0] din;
        logic [31:0] expDes;   // DES bit 1 as MSB
        string       name;
    } vecT;

    vecT vecs [6];

    function automatic logic [31:0] bitRev(input logic [31:0] x);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[31-i] = x[i];
        return r;
    endfunction

    // Expected DataOut (DataOut[0] = DES bit 1) for a 48-bit input word.
    function automatic logic [31:0] modelOut(input logic [47:0] w);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            logic [5:0] c;
            int         row;
            int         col;
            int         v;
            c   = w[6*k +: 6];
            row = {c[0], c[5]};
            col = {c[1], c[2], c[3], c[4]};
            v   = tbSbox[k][row*16 + col];
            for (int j = 0; j < 4; j++) r[4*k + j] = v[3-j];
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        totalCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: actual %h required %h", name, act, exp);
    endtask

    // Offer one word to all instances with OutReady high; record per-instance
    // latency (edges after the accept edge) and the presented data.
    task automatic runWord(input logic [47:0] w);
        bit done [4];
        int cyc;
        for (int i = 0; i < 4; i++) begin
            lat[i]  = -1;
            got[i]  = '0;
            done[i] = 1'b0;
        end
        check("inReadyBeforeAccept", 32'({irV[3], irV[2], irV[1], irV[0]}), 32'hF);
        inValid  = 1'b1;
        dataIn   = w;
        outReady = 1'b1;
        tick();
        inValid = 1'b0;
        dataIn  = 48'({$urandom(), $urandom()});
        cyc     = 0;
        while (cyc < 20 && !(done[0] && done[1] && done[2] && done[3])) begin
            tick();
            cyc++;
            for (int i = 0; i < 4; i++) begin
                if (!done[i] && ovV[i]) begin
                    done[i] = 1'b1;
                    lat[i]  = cyc;
                    got[i]  = dout[i];
                end
            end
        end
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passCnt, totalCnt);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int seen;
        int n;

        vecs[0] = '{48'h000000000000, 32'hEFA72C4D, "zero"};
        vecs[1] = '{48'h000000000036, 32'h5FA72C4D, "s1Row1Col13"};
        vecs[2] = '{48'hFFFFFFFFFFFF, 32'hD9CE3DCB, "allOnes"};
        vecs[3] = '{48'h041041041041, 32'h40DA4917, "row2Col0"};
        vecs[4] = '{48'h820820820820, 32'h03DDEAD1, "row1Col0"};
        vecs[5] = '{48'h79E79E79E79E, 32'h7A8F9B17, "row0Col15"};

        // Reset and idle
        tick(); tick(); tick();
        check("rst.inReady",  32'(irV[0]),   32'd0);
        check("rst.outValid", 32'(ovV[0]),   32'd0);
        check("rst.dataOut",  dout[0],       32'd0);
        check("rst.busy",     32'(busyV[0]), 32'd0);
        Rst = 1'b0;
        #1;
        check("release.inReady", 32'(irV[0]), 32'd1);
        tick();
        check("idle.inReady",  32'(irV[0]),   32'd1);
        check("idle.outValid", 32'(ovV[0]),   32'd0);
        check("idle.busy",     32'(busyV[0]), 32'd0);
        check("idle.dataOut",  dout[0],       32'd0);

        // Directed vectors on every lane setting
        for (int v = 0; v < 6; v++) begin
            runWord(vecs[v].din);
            for (int i = 0; i < 4; i++) begin
                check($sformatf("%s.L%0d.data", vecs[v].name, 1 << i), bitRev(got[i]), vecs[v].expDes);
                check($sformatf("%s.L%0d.latency", vecs[v].name, 1 << i), 32'(lat[i]), 32'(8 >> i));
            end
        end

        // All-zero word: explicit bit positions
        runWord(48'h0);
        check("zero.bit0", 32'(got[0][0]), 32'd1);
        check("zero.bit3", 32'(got[0][3]), 32'd0);

        // Backpressure in DONE
        inValid  = 1'b1;
        dataIn   = 48'h000000000036;
        outReady = 1'b0;
        tick();
        inValid = 1'b0;
        n = 0;
        while (!ovV[0] && n < 20) begin
            tick();
            n++;
        end
        check("bp.reachedDone", 32'(ovV[0]), 32'd1);
        for (int c = 0; c < 5; c++) begin
            inValid = ~inValid;
            dataIn  = 48'({$urandom(), $urandom()});
            tick();
            check("bp.dataStable", bitRev(dout[0]), 32'h5FA72C4D);
            check("bp.inReady",    32'(irV[0]),     32'd0);
            check("bp.outValid",   32'(ovV[0]),     32'd1);
        end
        inValid  = 1'b0;
        outReady = 1'b1;
        tick();
        check("bp.exit.outValid", 32'(ovV[0]),     32'd0);
        check("bp.exit.inReady",  32'(irV[0]),     32'd1);
        check("bp.exit.busy",     32'(busyV[0]),   32'd0);
        check("bp.exit.dataKept", bitRev(dout[0]), 32'h5FA72C4D);

        // Reset mid-RUN
        inValid = 1'b1;
        dataIn  = 48'hFFFFFFFFFFFF;
        tick();
        inValid = 1'b0;
        tick(); tick(); tick();
        check("rstRun.busyBefore", 32'(busyV[0]), 32'd1);
        Rst = 1'b1;
        #1;
        check("rstRun.outValid", 32'(ovV[0]),   32'd0);
        check("rstRun.busy",     32'(busyV[0]), 32'd0);
        check("rstRun.dataOut",  dout[0],       32'd0);
        check("rstRun.inReady",  32'(irV[0]),   32'd0);
        tick(); tick();
        Rst  = 1'b0;
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (ovV[0] || ovV[1]) seen++;
        end
        check("rstRun.noStaleOutput", 32'(seen), 32'd0);
        runWord(48'h041041041041);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rstRun.next.L%0d.data", 1 << i), bitRev(got[i]), 32'h40DA4917);
            check($sformatf("rstRun.next.L%0d.latency", 1 << i), 32'(lat[i]), 32'(8 >> i));
        end

        // Random sweep against the table model
        for (int k = 0; k < 100; k++) begin
            logic [47:0] w;
            logic [31:0] exp;
            w   = 48'({$urandom(), $urandom()});
            exp = modelOut(w);
            runWord(w);
            for (int i = 0; i < 4; i++) begin
                check($sformatf("sweep%0d.L%0d.data", k, 1 << i), got[i], exp);
                check($sformatf("sweep%0d.L%0d.latency", k, 1 << i), 32'(lat[i]), 32'(8 >> i));
            end
        end

        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end

endmodule
